button_event_arbiter: RTL

Multi-button front end for the reaction timer. It synchronizes and debounces N raw push-button inputs from one shared sample tick and turns each debounced press into a one-shot event. Pending events are serialized onto a single valid/ready event port using round-robin arbitration. It sits between the board pins and the game FSM, replacing per-button debouncer instances.

---
 rtl/button_event_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/button_event_arbiter.sv
// Debounces N push buttons on a shared sample tick and serializes press events round-robin.
// Optional long-press events are enabled with `define BUTTON_LONG_PRESS_EN.
module button_event_arbiter #(
  parameter int N_BUTTONS      = 4,
  parameter int TICK_DIV       = 5,
  parameter int STABLE_SAMPLES = 7,
  parameter int LONG_TICKS     = 200
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BUTTONS-1:0]         buttonIn,
  output logic [N_BUTTONS-1:0]         buttonLevel,
  output logic                         evtValid,
  input  logic                         evtReady,
  output logic [$clog2(N_BUTTONS)-1:0] evtId,
  output logic                         evtLong,
  output logic [N_BUTTONS-1:0]         pendingMask,
  output logic                         droppedEvt
);

  localparam int ID_W = $clog2(N_BUTTONS);
  localparam int TW   = $clog2(TICK_DIV);
  localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [ID_W-1:0] GRANT_INIT = ID_W'(N_BUTTONS - 1);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
  logic [N_BUTTONS-1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [STABLE_SAMPLES-1:0] samp_q [N_BUTTONS];
  logic [STABLE_SAMPLES-1:0] samp_d [N_BUTTONS];
  logic [N_BUTTONS-1:0]      level_q, level_d, level_prev_q, level_prev_d;
  logic [N_BUTTONS-1:0]      pending_q, pending_d;
  logic                      dropped_q, dropped_d;
  state_t                    state_q, state_d;
  logic                      evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]           evt_id_q, evt_id_d;
  logic [ID_W-1:0]           last_grant_q, last_grant_d;

  logic                      tick;
  logic [N_BUTTONS-1:0]      press, clr_short;
  logic                      grant_found, grant_long, do_grant, drop;
  logic [ID_W-1:0]           grant_idx;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_TICKS + 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_TICKS);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);

  logic [LW-1:0]        hold_cnt_q [N_BUTTONS];
  logic [LW-1:0]        hold_cnt_d [N_BUTTONS];
  logic [N_BUTTONS-1:0] long_pending_q, long_pending_d;
  logic [N_BUTTONS-1:0] long_set, clr_long;
  logic                 evt_long_q, evt_long_d;
`endif

  always_comb begin
    int idx;
    idx = 0;

    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    sync1_d    = buttonIn;
    sync2_d    = sync1_q;
    level_prev_d = level_q;

    for (int i = 0; i < N_BUTTONS; i++) begin
      samp_d[i]  = tick ? {samp_q[i][STABLE_SAMPLES-2:0], sync2_q[i]} : samp_q[i];
      level_d[i] = level_q[i];
      if (&samp_q[i])       level_d[i] = 1'b1;
      else if (~|samp_q[i]) level_d[i] = 1'b0;
    end

    press = level_q & ~level_prev_q;

    // Scan upward from the button after the last one granted; short before long per button.
    grant_found = 1'b0;
    grant_long  = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_BUTTONS; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= N_BUTTONS) idx = idx - N_BUTTONS;
      if (!grant_found) begin
        if (pending_q[idx]) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'(idx);
        end
`ifdef BUTTON_LONG_PRESS_EN
        else if (long_pending_q[idx]) begin
          grant_found = 1'b1;
          grant_long  = 1'b1;
          grant_idx   = ID_W'(idx);
        end
`endif
      end
    end

    do_grant = (state_q == S_IDLE) && grant_found;
    for (int i = 0; i < N_BUTTONS; i++) begin
      clr_short[i] = do_grant && !grant_long && (grant_idx == ID_W'(i));
    end

    // A press that coincides with the grant of the same bit re-arms it rather than dropping.
    pending_d = (pending_q & ~clr_short) | press;
    drop      = |(press & pending_q & ~clr_short);

`ifdef BUTTON_LONG_PRESS_EN
    for (int i = 0; i < N_BUTTONS; i++) begin
      clr_long[i] = do_grant && grant_long && (grant_idx == ID_W'(i));
      long_set[i] = tick && level_q[i] && (hold_cnt_q[i] == LONG_LAST);
      if (!level_q[i])
        hold_cnt_d[i] = '0;
      else if (tick && (hold_cnt_q[i] != LONG_MAX))
        hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
      else
        hold_cnt_d[i] = hold_cnt_q[i];
    end
    long_pending_d = (long_pending_q & ~clr_long) | long_set;
    drop           = drop | (|(long_set & long_pending_q & ~clr_long));
    evt_long_d     = evt_long_q;
`endif

    dropped_d = dropped_q | drop;

    state_d      = state_q;
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (do_grant) begin
          evt_valid_d = 1'b1;
          evt_id_d    = grant_idx;
`ifdef BUTTON_LONG_PRESS_EN
          evt_long_d  = grant_long;
`endif
          state_d     = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (evtReady) begin
          evt_valid_d  = 1'b0;
          last_grant_d = evt_id_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q   <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      for (int i = 0; i < N_BUTTONS; i++) samp_q[i] <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      pending_q    <= '0;
      dropped_q    <= 1'b0;
      state_q      <= S_IDLE;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      last_grant_q <= GRANT_INIT;
`ifdef BUTTON_LONG_PRESS_EN
      for (int i = 0; i < N_BUTTONS; i++) hold_cnt_q[i] <= '0;
      long_pending_q <= '0;
      evt_long_q     <= 1'b0;
`endif
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      samp_q       <= samp_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      pending_q    <= pending_d;
      dropped_q    <= dropped_d;
      state_q      <= state_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
`ifdef BUTTON_LONG_PRESS_EN
      hold_cnt_q     <= hold_cnt_d;
      long_pending_q <= long_pending_d;
      evt_long_q     <= evt_long_d;
`endif
    end
  end

  assign buttonLevel = level_q;
  assign evtValid    = evt_valid_q;
  assign evtId       = evt_id_q;
  assign pendingMask = pending_q;
  assign droppedEvt  = dropped_q;
`ifdef BUTTON_LONG_PRESS_EN
  assign evtLong     = evt_long_q;
`else
  assign evtLong     = 1'b0;
`endif

endmodule
